// File: rtl/cmd_packet_parser.sv
// Byte-stream command parser: decodes 3-byte headers, assembles write payloads
// into BRAM-width words and issues handshaked read requests.
module cmd_packet_parser #(
    parameter int DATA_WIDTH     = 64,
    parameter int DATA_WORDS     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  byte_valid_in,
    input  logic [7:0]            byte_in,
    output logic                  wr_valid_out,
    output logic                  wr_target_out,
    output logic [ADDR_WIDTH-1:0] wr_addr_out,
    output logic [DATA_WIDTH-1:0] wr_data_out,
    output logic                  rd_valid_out,
    input  logic                  rd_ready_in,
    output logic                  rd_target_out,
    output logic [ADDR_WIDTH-1:0] rd_addr_out,
    output logic                  busy_out,
    output logic                  err_out
);

    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int BYTE_CNT_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int WORD_CNT_W     = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam int IDLE_CNT_W     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] ST_HDR0     = 3'd0;
    localparam logic [2:0] ST_HDR1     = 3'd1;
    localparam logic [2:0] ST_HDR2     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD  = 3'd3;
    localparam logic [2:0] ST_READ_REQ = 3'd4;

    localparam logic [7:0] OP_WRITE_DATA = 8'h00;
    localparam logic [7:0] OP_WRITE_OP   = 8'h02;
    localparam logic [7:0] OP_READ_DATA  = 8'h04;
    localparam logic [7:0] OP_READ_INF   = 8'h07;

    logic [2:0]            state_reg;
    logic [7:0]            opcode_reg;
    logic [7:0]            addr_lo_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [BYTE_CNT_W-1:0] byte_cnt_reg;
    logic [WORD_CNT_W-1:0] word_cnt_reg;
    logic [DATA_WIDTH-1:0] word_buf_reg;
    logic [IDLE_CNT_W-1:0] idle_cnt_reg;

    logic                  wr_valid_reg;
    logic                  wr_target_reg;
    logic [ADDR_WIDTH-1:0] wr_addr_reg;
    logic [DATA_WIDTH-1:0] wr_data_reg;
    logic                  rd_valid_reg;
    logic                  rd_target_reg;
    logic [ADDR_WIDTH-1:0] rd_addr_reg;
    logic                  err_reg;

    logic [15:0]           hdr_addr16;
    logic [ADDR_WIDTH-1:0] hdr_addr;
    logic [DATA_WIDTH-1:0] word_next;
    logic                  timed_state;
    logic                  timeout_hit;
    logic                  word_last_byte;
    logic                  last_word;

    assign hdr_addr16 = {byte_in, addr_lo_reg};

    // Header address is 16 bits on the wire; fit it to ADDR_WIDTH.
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_WIDTH; gi++) begin : g_addr
            if (gi < 16) begin : g_copy
                assign hdr_addr[gi] = hdr_addr16[gi];
            end else begin : g_zero
                assign hdr_addr[gi] = 1'b0;
            end
        end
    endgenerate

    // Little-endian lane insert: byte k of a word lands in bits [8k+7:8k].
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            assign word_next[gi*8 +: 8] = (byte_cnt_reg == BYTE_CNT_W'(gi)) ?
                                          byte_in : word_buf_reg[gi*8 +: 8];
        end
    endgenerate

    assign timed_state    = (state_reg == ST_HDR1) || (state_reg == ST_HDR2) ||
                            (state_reg == ST_PAYLOAD);
    assign timeout_hit    = timed_state && !byte_valid_in &&
                            (idle_cnt_reg == IDLE_CNT_W'(TIMEOUT_CYCLES - 1));
    assign word_last_byte = (byte_cnt_reg == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    assign last_word      = (word_cnt_reg == WORD_CNT_W'(DATA_WORDS - 1));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg     <= ST_HDR0;
            opcode_reg    <= '0;
            addr_lo_reg   <= '0;
            addr_reg      <= '0;
            byte_cnt_reg  <= '0;
            word_cnt_reg  <= '0;
            word_buf_reg  <= '0;
            idle_cnt_reg  <= '0;
            wr_valid_reg  <= 1'b0;
            wr_target_reg <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            rd_target_reg <= 1'b0;
            rd_addr_reg   <= '0;
            err_reg       <= 1'b0;
        end else begin
            wr_valid_reg <= 1'b0;
            err_reg      <= 1'b0;

            if (timed_state && !byte_valid_in)
                idle_cnt_reg <= idle_cnt_reg + IDLE_CNT_W'(1);
            else
                idle_cnt_reg <= '0;

            if (timeout_hit) begin
                // Abandon the packet; any partial word is simply forgotten.
                state_reg    <= ST_HDR0;
                err_reg      <= 1'b1;
                byte_cnt_reg <= '0;
                idle_cnt_reg <= '0;
            end else begin
                case (state_reg)
                    ST_HDR0: begin
                        if (byte_valid_in) begin
                            opcode_reg <= byte_in;
                            state_reg  <= ST_HDR1;
                        end
                    end
                    ST_HDR1: begin
                        if (byte_valid_in) begin
                            addr_lo_reg <= byte_in;
                            state_reg   <= ST_HDR2;
                        end
                    end
                    ST_HDR2: begin
                        if (byte_valid_in) begin
                            case (opcode_reg)
                                OP_WRITE_DATA, OP_WRITE_OP: begin
                                    addr_reg     <= hdr_addr;
                                    byte_cnt_reg <= '0;
                                    word_cnt_reg <= '0;
                                    state_reg    <= ST_PAYLOAD;
                                end
                                OP_READ_DATA, OP_READ_INF: begin
                                    rd_valid_reg  <= 1'b1;
                                    rd_target_reg <= (opcode_reg == OP_READ_INF);
                                    rd_addr_reg   <= hdr_addr;
                                    state_reg     <= ST_READ_REQ;
                                end
                                default: begin
                                    err_reg   <= 1'b1;
                                    state_reg <= ST_HDR0;
                                end
                            endcase
                        end
                    end
                    ST_PAYLOAD: begin
                        if (byte_valid_in) begin
                            if (opcode_reg == OP_WRITE_OP) begin
                                wr_valid_reg  <= 1'b1;
                                wr_target_reg <= 1'b1;
                                wr_addr_reg   <= addr_reg;
                                wr_data_reg   <= DATA_WIDTH'(byte_in);
                                state_reg     <= ST_HDR0;
                            end else if (word_last_byte) begin
                                wr_valid_reg  <= 1'b1;
                                wr_target_reg <= 1'b0;
                                wr_addr_reg   <= addr_reg;
                                wr_data_reg   <= word_next;
                                word_buf_reg  <= word_next;
                                addr_reg      <= addr_reg + ADDR_WIDTH'(1);
                                byte_cnt_reg  <= '0;
                                word_cnt_reg  <= word_cnt_reg + WORD_CNT_W'(1);
                                if (last_word)
                                    state_reg <= ST_HDR0;
                            end else begin
                                word_buf_reg <= word_next;
                                byte_cnt_reg <= byte_cnt_reg + BYTE_CNT_W'(1);
                            end
                        end
                    end
                    ST_READ_REQ: begin
                        // Incoming bytes are dropped until the request is taken.
                        if (rd_valid_reg && rd_ready_in) begin
                            rd_valid_reg <= 1'b0;
                            state_reg    <= ST_HDR0;
                        end
                    end
                    default: state_reg <= ST_HDR0;
                endcase
            end
        end
    end

    assign wr_valid_out  = wr_valid_reg;
    assign wr_target_out = wr_target_reg;
    assign wr_addr_out   = wr_addr_reg;
    assign wr_data_out   = wr_data_reg;
    assign rd_valid_out  = rd_valid_reg;
    assign rd_target_out = rd_target_reg;
    assign rd_addr_out   = rd_addr_reg;
    assign err_out       = err_reg;
    assign busy_out      = (state_reg != ST_HDR0);

endmodule

// File: doc/cmd_packet_parser.md
CMD_PACKET_PARSER -- requirements
Module: cmd_packet_parser

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: data BRAM word width in bits, a multiple of 8.
REQ-002 SHALL have parameter DATA_WORDS, default 32: number of words in one WRITE_DATA payload.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16: write/read address width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100000: inter-byte idle limit inside a packet.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk_in, input, 1 bit: system clock.
REQ-007 SHALL have port rst_in, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port byte_valid_in, input, 1 bit: one-cycle strobe from the UART receiver.
REQ-009 SHALL have port byte_in, input, 8 bits: received byte, qualified by byte_valid_in.
REQ-010 SHALL have port wr_valid_out, output, 1 bit: one-cycle write strobe.
REQ-011 SHALL have port wr_target_out, output, 1 bit: write target, 0 = data BRAM, 1 = op BRAM.
REQ-012 SHALL have port wr_addr_out, output, ADDR_WIDTH bits: write address.
REQ-013 SHALL have port wr_data_out, output, DATA_WIDTH bits: write data; op writes use bits [7:0] with upper bits zero.
REQ-014 SHALL have port rd_valid_out, output, 1 bit: read request pending.
REQ-015 SHALL have port rd_ready_in, input, 1 bit: read request accepted by the transmit path.
REQ-016 SHALL have port rd_target_out, output, 1 bit: read target, 0 = data, 1 = inference.
REQ-017 SHALL have port rd_addr_out, output, ADDR_WIDTH bits: read address.
REQ-018 SHALL have port busy_out, output, 1 bit: high in every state except HDR0.
REQ-019 SHALL have port err_out, output, 1 bit: one-cycle pulse on an unknown opcode or a timeout.

Function
REQ-020 SHALL treat each packet as a 3-byte header: byte0 = opcode; byte1 = address[7:0]; byte2 = address[15:8], truncated or zero-extended to ADDR_WIDTH.
REQ-021 SHALL decode opcodes as: 0x00 WRITE_DATA, 0x02 WRITE_OP, 0x04 READ_DATA, 0x07 READ_INFERENCE; all other values are unknown.
REQ-022 SHALL implement the states HDR0, HDR1, HDR2, PAYLOAD and READ_REQ.
REQ-023 SHALL move HDR0->HDR1->HDR2 on each byte_valid_in; on the byte that completes the header, go to PAYLOAD for write opcodes and to READ_REQ for read opcodes.
REQ-024 SHALL, on an unknown opcode, go from HDR2 to HDR0 and pulse err_out the cycle after byte2.
REQ-025 SHALL, for WRITE_DATA, assemble bytes little-endian: the first payload byte goes into bits [7:0] of the word.
REQ-026 SHALL pulse wr_valid_out for one cycle after each DATA_WIDTH/8 payload bytes, with wr_data_out, wr_addr_out and wr_target_out=0 valid in that cycle.
REQ-027 SHALL use the header address for the first WRITE_DATA word and increment it by 1 per word, wrapping modulo 2^ADDR_WIDTH.
REQ-028 SHALL return to HDR0 after the DATA_WORDS-th word is written.
REQ-029 SHALL, for WRITE_OP, accept exactly one payload byte, pulse wr_valid_out with wr_target_out=1 and the header address, then return to HDR0.
REQ-030 SHALL register the write strobe: latency is exactly 1 cycle from the completing byte_valid_in to wr_valid_out.
REQ-031 SHALL, in READ_REQ, assert rd_valid_out with stable rd_target_out and rd_addr_out until a cycle where rd_valid_out and rd_ready_in are both high, then go to HDR0 on the next cycle.
REQ-032 SHALL discard any byte arriving in READ_REQ.
REQ-033 SHALL keep an idle counter in HDR1, HDR2 and PAYLOAD that clears on every byte_valid_in.
REQ-034 SHALL, when the idle counter reaches TIMEOUT_CYCLES, go to HDR0, pulse err_out and drop any partially assembled word without writing it.
REQ-035 SHALL not apply the timeout in READ_REQ.
REQ-036 SHALL hold wr_data_out at its last value between strobes.

Reset
REQ-037 SHALL, when rst_in is high on a clock edge, set the state to HDR0, clear all counters and set every output to 0, including mid-packet and mid-read-request.
REQ-038 SHALL ignore byte_valid_in in any cycle where rst_in is high.

Verification
REQ-039 SHALL pass: header 00 00 00, then 256 bytes with byte n = n mod 256 (DATA_WIDTH=64) -> 32 wr_valid_out pulses, target 0, addresses 0..31, first word 0x0706050403020100.
REQ-040 SHALL pass: header 02 05 00, then byte 0x07 -> one pulse, target 1, address 5, data 0x07; busy_out returns low the next cycle.
REQ-041 SHALL pass: header 07 00 00 with rd_ready_in held low for 10 cycles then high -> rd_valid_out high 11 cycles, target 1; a byte injected during the wait produces no write.
REQ-042 SHALL pass: header 09 00 00 -> err_out pulses once, no strobes; next header 04 00 00 raises rd_valid_out with target 0.
REQ-043 SHALL pass: WRITE_DATA with TIMEOUT_CYCLES=50, stalled after 3 payload bytes -> err_out pulses at idle cycle 50, no write, state HDR0.
REQ-044 SHALL pass: rst_in asserted mid-payload -> all outputs 0 next cycle; a following WRITE_OP at address 1 completes normally.
